cic_decimator_iq: RTL and testbench
===================================

// Module: cic_decimator_iq
// PURPOSE
//   Dual-channel (I/Q) CIC decimator directly downstream of the mixer.
//   Consumes MixerOutSin/MixerOutCos every clk and produces baseband I/Q
//   at clk/DECIM_RATIO.
//   One decimation counter is shared by both channels, so I and Q samples
//   stay phase-aligned. Output feeds the later FIR/demodulator stages.
// PARAMETERS
//   IN_WIDTH    12    signed input width (matches mixer WIDTH)
//   OUT_WIDTH   12    signed output width
//   STAGES      3     CIC order N (integrator count = comb count), >=1
//   LOG2_DECIM  12    log2 of decimation ratio; DECIM_RATIO = 2**LOG2_DECIM
//   ACC_WIDTH   IN_WIDTH+STAGES*LOG2_DECIM (=48)   derived localparam, not overridable
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   rst        in   1          asynchronous, active-high reset
//   in_i       in   IN_WIDTH   signed I sample (mixer sin output), one per clk
//   in_q       in   IN_WIDTH   signed Q sample (mixer cos output), one per clk
//   out_i      out  OUT_WIDTH  signed decimated I, held between strobes
//   out_q      out  OUT_WIDTH  signed decimated Q, held between strobes
//   out_valid  out  1          one-clk pulse when out_i/out_q update
// BEHAVIOUR
//   - Reset (async assert, sync release): all integrators, comb registers,
//     comb delays, sample regs, decimation counter, strobe pipe, out_i, out_q
//     and out_valid go to 0.
//   - Integrators run every clk:
//       int0 <= int0 + sext(in)
//       intk <= intk + int(k-1)
//     All arithmetic is two's complement, ACC_WIDTH bits. Wrap-around is
//     intentional and must not saturate; combs cancel the wrap.
//   - Decimation counter: LOG2_DECIM bits, increments every clk, wraps
//     DECIM_RATIO-1 -> 0.
//   - Strobe: high during the cycle where counter == DECIM_RATIO-1. At the
//     closing edge, sample_reg <= int(STAGES-1) (register value, pre-update).
//   - Comb pipeline: comb stage k updates only at strobe-delay k+1
//     (shift-register pipe):
//       ck <= x - dk;  dk <= x
//     x = sample_reg for k=0, else c(k-1). Each comb updates exactly once
//     per decimated sample.
//   - Output: at strobe-delay STAGES+1:
//       out_* <= c(STAGES-1)[ACC_WIDTH-1 -: OUT_WIDTH]  (truncation, no rounding)
//     out_valid=1 for that cycle only. Latency is STAGES+1 clks from the
//     sampling edge.
//   - First out_valid after reset release is at rising edge
//     DECIM_RATIO+STAGES+1 (edge 1 = first edge after release); thereafter
//     every DECIM_RATIO clks.
//   - DC gain = DECIM_RATIO**STAGES = 2**(ACC_WIDTH-IN_WIDTH). With
//     OUT_WIDTH==IN_WIDTH, steady-state DC out equals DC in. The first
//     STAGES outputs after reset are transient.
//   - Constraint: DECIM_RATIO >= STAGES+2. Check at elaboration;
//     $error on violation.
//   - Reset mid-operation: the in-flight decimated sample is discarded and
//     no out_valid is emitted for it. Timing restarts as after power-up.
//   - I and Q datapaths are identical and share the counter/strobe pipe.
//     out_valid covers both.
// STRUCTURE
//   - Shared package sdr_pkg: CIC_STAGES, CIC_LOG2_DECIM, CIC_ACC_WIDTH
//     (derived) and the MIXER/CIC sample width, so mixer, CIC and
//     downstream agree.
//   - Sub-module cic_channel: one channel of integrators, sample reg, combs
//     and output truncation.
//     Inputs: sample, strobe-pipe taps.  Output: out.
//     Instantiated twice (I, Q). Top holds the counter, strobe shift
//     register and out_valid.
// TESTING (STAGES=3, LOG2_DECIM=12, 12-bit in/out unless noted)
//   1. rst pulse mid-run, asynchronous between edges:
//      -> all outputs 0 immediately, no out_valid until edge 4100
//         after release.
//   2. in_i=+1000, in_q=-500 constant:
//      -> out_valid every 4096 clks, first at edge 4100;
//         from the 4th output on, out_i=1000, out_q=-500 exactly.
//   3. in_i=+2047, in_q=-2048 constant (full scale):
//      -> steady out_i=2047, out_q=-2048, no wrap error (checks ACC_WIDTH).
//   4. in_i alternating +1000/-1000 each clk (mixer with toggling RF):
//      -> steady-state out_i=0 exactly.
//   5. Step 0 -> +512 on in_i at an arbitrary cycle:
//      -> outputs follow the CIC step response, monotonic, reaching 512
//         within 3 outputs; compare against a bit-true reference model.
//   6. LOG2_DECIM=2, STAGES=3 (DECIM=4, below the limit):
//      -> elaboration error.
//      LOG2_DECIM=3, STAGES=3:
//      -> out_valid every 8 clks, model-matched.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared SDR receive-chain constants so mixer, CIC and downstream stages agree on widths.
package sdr_pkg;

   // Mixer output / CIC sample width.
   localparam int unsigned SAMPLE_WIDTH   = 12;
   localparam int unsigned CIC_STAGES     = 3;
   localparam int unsigned CIC_LOG2_DECIM = 12;

   // Bit growth of a CIC is STAGES*log2(R). The accumulator must hold the full DC gain.
   function automatic int unsigned cic_acc_width(input int unsigned in_w,
                                                 input int unsigned stages,
                                                 input int unsigned log2_decim);
      return in_w + stages * log2_decim;
   endfunction

   localparam int unsigned CIC_ACC_WIDTH =
      cic_acc_width(SAMPLE_WIDTH, CIC_STAGES, CIC_LOG2_DECIM);

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: integrator cascade, decimation sample register, comb pipe and truncation.
module cic_channel
   import sdr_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = SAMPLE_WIDTH,
   parameter int unsigned OUT_WIDTH = SAMPLE_WIDTH,
   parameter int unsigned STAGES    = CIC_STAGES,
   parameter int unsigned ACC_WIDTH = CIC_ACC_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [IN_WIDTH-1:0]  i_sample,
   input  logic                        i_strobe,
   input  logic [STAGES:0]             i_stb_pipe,
   output logic signed [OUT_WIDTH-1:0] o_out
);

   logic [ACC_WIDTH-1:0]        r_integ   [STAGES];
   logic [ACC_WIDTH-1:0]        r_comb    [STAGES];
   logic [ACC_WIDTH-1:0]        r_delay   [STAGES];
   logic [ACC_WIDTH-1:0]        w_integ_in[STAGES];
   logic [ACC_WIDTH-1:0]        w_comb_in [STAGES];
   logic [ACC_WIDTH-1:0]        w_sample_ext;
   logic [ACC_WIDTH-1:0]        r_sample;
   logic signed [OUT_WIDTH-1:0] r_out;

   assign w_sample_ext = {{(ACC_WIDTH - IN_WIDTH){i_sample[IN_WIDTH-1]}}, i_sample};

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign w_integ_in[g] = w_sample_ext;
         assign w_comb_in[g]  = r_sample;
      end else begin : g_rest
         assign w_integ_in[g] = r_integ[g-1];
         assign w_comb_in[g]  = r_comb[g-1];
      end

      // Integrator: free-running modular accumulation; wrap is cancelled by the combs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_integ[g] <= '0;
         end else begin
            r_integ[g] <= r_integ[g] + w_integ_in[g];
         end
      end

      // Comb: differentiate once per decimated sample when its strobe tap arrives.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_comb[g]  <= '0;
            r_delay[g] <= '0;
         end else if (i_stb_pipe[g]) begin
            r_comb[g]  <= w_comb_in[g] - r_delay[g];
            r_delay[g] <= w_comb_in[g];
         end
      end
   end

   // Capture the last integrator (pre-update value) on the decimation strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample <= '0;
      end else if (i_strobe) begin
         r_sample <= r_integ[STAGES-1];
      end
   end

   // Output keeps the top OUT_WIDTH bits (truncation) and holds between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= '0;
      end else if (i_stb_pipe[STAGES]) begin
         r_out <= $signed(r_comb[STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH]);
      end
   end

   assign o_out = r_out;

endmodule

// File: rtl/cic_decimator_iq.sv
// Dual-channel I/Q CIC decimator; one shared counter/strobe pipe keeps I and Q phase-aligned.
module cic_decimator_iq
   import sdr_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = SAMPLE_WIDTH,
   parameter int unsigned OUT_WIDTH  = SAMPLE_WIDTH,
   parameter int unsigned STAGES     = CIC_STAGES,
   parameter int unsigned LOG2_DECIM = CIC_LOG2_DECIM
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [IN_WIDTH-1:0]  in_i,
   input  logic signed [IN_WIDTH-1:0]  in_q,
   output logic signed [OUT_WIDTH-1:0] out_i,
   output logic signed [OUT_WIDTH-1:0] out_q,
   output logic                        out_valid
);

   localparam int unsigned ACC_WIDTH   = cic_acc_width(IN_WIDTH, STAGES, LOG2_DECIM);
   localparam int unsigned DECIM_RATIO = 1 << LOG2_DECIM;

   // The strobe pipe must drain before the next strobe enters it.
   if (STAGES < 1 || DECIM_RATIO < STAGES + 2) begin : g_bad_cfg
      $error("cic_decimator_iq: need STAGES>=1 and 2**LOG2_DECIM >= STAGES+2");
   end
   if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_width
      $error("cic_decimator_iq: OUT_WIDTH exceeds accumulator width");
   end

   logic [LOG2_DECIM-1:0] r_cnt;
   logic [STAGES:0]       r_stb_pipe;
   logic                  r_out_valid;
   logic                  w_strobe;

   assign w_strobe = (r_cnt == '1);

   // Decimation counter and strobe delay line; bit k enables comb k, bit STAGES the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_stb_pipe  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_cnt       <= r_cnt + 1'b1;
         r_stb_pipe  <= {r_stb_pipe[STAGES-1:0], w_strobe};
         r_out_valid <= r_stb_pipe[STAGES];
      end
   end

   cic_channel #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .STAGES    (STAGES),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_chan_i (
      .clk        (clk),
      .rst        (rst),
      .i_sample   (in_i),
      .i_strobe   (w_strobe),
      .i_stb_pipe (r_stb_pipe),
      .o_out      (out_i)
   );

   cic_channel #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .STAGES    (STAGES),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_chan_q (
      .clk        (clk),
      .rst        (rst),
      .i_sample   (in_q),
      .i_strobe   (w_strobe),
      .i_stb_pipe (r_stb_pipe),
      .o_out      (out_q)
   );

   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cic_decimator_iq.sv
// Scoreboard bench: two decimators (R=4096 and R=8, 3 stages) against a moving-sum CIC model.
module tb_cic_decimator_iq;

   localparam int STAGES     = 3;
   localparam int R_BIG      = 4096;
   localparam int R_SMALL    = 8;
   localparam int SHIFT_BIG  = 36;  // log2(R_BIG**3)
   localparam int SHIFT_SMALL = 9;  // log2(R_SMALL**3)

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [11:0] in_i0 = '0, in_q0 = '0, in_i1 = '0, in_q1 = '0;
   logic signed [11:0] out_i0, out_q0, out_i1, out_q1;
   logic               out_valid0, out_valid1;

   always #5 clk = ~clk;

   cic_decimator_iq u_dut_big (
      .clk       (clk),
      .rst       (rst),
      .in_i      (in_i0),
      .in_q      (in_q0),
      .out_i     (out_i0),
      .out_q     (out_q0),
      .out_valid (out_valid0)
   );

   cic_decimator_iq #(
      .LOG2_DECIM (3)
   ) u_dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_i      (in_i1),
      .in_q      (in_q1),
      .out_i     (out_i1),
      .out_q     (out_q1),
      .out_valid (out_valid1)
   );

   typedef struct {
      int     edge_n;
      longint i;
      longint q;
   } exp_t;

   exp_t   exp0[$];
   exp_t   exp1[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     edge_cnt = 0;  // rising edges since reset release (edge 1 = first)
   int     phase    = 0;
   longint prev_q0  = 0;

   // Input history per channel, indexed by edge: 0/1 = big I/Q, 2/3 = small I/Q.
   longint hist [4][0:32767];
   longint b1 [0:8191];
   longint b2 [0:4095];

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   function automatic longint xv(input int ch, input int e);
      if (e < 1) return 0;
      return hist[ch][e];
   endfunction

   // CIC = STAGES cascaded length-R moving sums, read at edge t, scaled by 2**-shift (floor).
   function automatic longint cic_ref(input int ch, input int r, input int t, input int shift);
      int     u0;
      longint s;
      u0 = t - 2 * r + 2;
      s  = 0;
      for (int e = u0 - r + 1; e <= u0; e++) s += xv(ch, e);
      b1[0] = s;
      for (int k = 1; k < 2 * r - 1; k++) begin
         s += xv(ch, u0 + k) - xv(ch, u0 + k - r);
         b1[k] = s;
      end
      s = 0;
      for (int k = 0; k < r; k++) s += b1[k];
      b2[0] = s;
      for (int j = 1; j < r; j++) begin
         s += b1[j + r - 1] - b1[j - 1];
         b2[j] = s;
      end
      s = 0;
      for (int j = 0; j < r; j++) s += b2[j];
      return s >>> shift;
   endfunction

   // One clock: record inputs seen at this edge, predict outputs for sampling edges.
   task automatic step();
      exp_t x;
      @(posedge clk);
      edge_cnt++;
      hist[0][edge_cnt] = longint'(in_i0);
      hist[1][edge_cnt] = longint'(in_q0);
      hist[2][edge_cnt] = longint'(in_i1);
      hist[3][edge_cnt] = longint'(in_q1);
      if (edge_cnt % R_BIG == 0) begin
         x.edge_n = edge_cnt + STAGES + 1;
         x.i = cic_ref(0, R_BIG, edge_cnt - STAGES, SHIFT_BIG);
         x.q = cic_ref(1, R_BIG, edge_cnt - STAGES, SHIFT_BIG);
         exp0.push_back(x);
      end
      if (edge_cnt % R_SMALL == 0) begin
         x.edge_n = edge_cnt + STAGES + 1;
         x.i = cic_ref(2, R_SMALL, edge_cnt - STAGES, SHIFT_SMALL);
         x.q = cic_ref(3, R_SMALL, edge_cnt - STAGES, SHIFT_SMALL);
         exp1.push_back(x);
      end
      #1;
   endtask

   task automatic fail_now(input string name, input int got_edge, input int req_edge);
      n_checks++;
      n_fail++;
      $display("FAIL %s: out_valid at edge %0d, expected edge %0d", name, got_edge, req_edge);
   endtask

   task automatic mon(input int d, input logic v, input longint oi, input longint oq);
      exp_t x;
      int   sz;
      sz = (d == 0) ? exp0.size() : exp1.size();
      if (v) begin
         if (sz == 0) begin
            fail_now($sformatf("d%0d unexpected valid", d), edge_cnt, -1);
         end else begin
            if (d == 0) x = exp0.pop_front();
            else        x = exp1.pop_front();
            check($sformatf("d%0d valid edge", d), edge_cnt, x.edge_n);
            check($sformatf("d%0d out_i", d), oi, x.i);
            check($sformatf("d%0d out_q", d), oq, x.q);
            if (d == 0 && phase == 3) begin
               check("d0 step monotonic", (oq >= prev_q0) ? 1 : 0, 1);
               prev_q0 = oq;
            end
         end
      end else if (sz > 0) begin
         x = (d == 0) ? exp0[0] : exp1[0];
         if (x.edge_n < edge_cnt) begin
            fail_now($sformatf("d%0d missing valid", d), -1, x.edge_n);
            if (d == 0) void'(exp0.pop_front());
            else        void'(exp1.pop_front());
         end
      end
   endtask

   // Monitor: sample on the falling edge, compare against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst) begin
         mon(0, out_valid0, longint'(out_i0), longint'(out_q0));
         mon(1, out_valid1, longint'(out_i1), longint'(out_q1));
      end
   end

   task automatic check_zero(input string tag);
      check({tag, " out_valid0"}, longint'(out_valid0), 0);
      check({tag, " out_i0"}, longint'(out_i0), 0);
      check({tag, " out_q0"}, longint'(out_q0), 0);
      check({tag, " out_valid1"}, longint'(out_valid1), 0);
      check({tag, " out_i1"}, longint'(out_i1), 0);
      check({tag, " out_q1"}, longint'(out_q1), 0);
   endtask

   // Asynchronous reset pulse between edges, with an in-flight sample being discarded.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check_zero("async rst");
      exp0.delete();
      exp1.delete();
      edge_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic rand_small();
      in_i1 = $signed(12'($urandom_range(0, 4095)));
      in_q1 = $signed(12'($urandom_range(0, 4095)));
   endtask

   initial begin
      int step_at;
      repeat (2) @(posedge clk);
      #1;
      check_zero("power-up rst");
      @(negedge clk);
      rst = 1'b0;

      // DC +1000 / -500; the sample taken at edge 20480 is in flight when reset hits.
      phase = 1;
      for (int n = 0; n < 20482; n++) begin
         in_i0 = 12'sd1000;
         in_q0 = -12'sd500;
         rand_small();
         step();
      end
      check("dc held out_i0", longint'(out_i0), 1000);
      check("dc held out_q0", longint'(out_q0), -500);
      do_reset();

      // Full-scale DC: accumulator must absorb 2**36 gain without error.
      phase = 2;
      for (int n = 0; n < 20482; n++) begin
         in_i0 = 12'sd2047;
         in_q0 = -12'sd2048;
         rand_small();
         step();
      end
      check("fs held out_i0", longint'(out_i0), 2047);
      check("fs held out_q0", longint'(out_q0), -2048);
      do_reset();

      // Alternating I rejects to 0; Q steps 0 -> 512 at a random edge.
      phase   = 3;
      prev_q0 = 0;
      step_at = 300 + int'($urandom_range(0, 1000));
      for (int n = 0; n < 16390; n++) begin
         in_i0 = (n % 2 == 0) ? 12'sd1000 : -12'sd1000;
         in_q0 = (n >= step_at) ? 12'sd512 : 12'sd0;
         rand_small();
         step();
      end
      check("alt held out_i0", longint'(out_i0), 0);
      check("step held out_q0", longint'(out_q0), 512);
      @(negedge clk);
      check("d0 pending overdue", longint'(exp0.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
